// File: rtl/mux_rr_n.sv
// mux_rr_n: N-input, WIDTH-bit registered stream multiplexer with valid/ready handshakes.
// Arbitration is round-robin by default. Define MUX_STRICT_PRIO_EN to get fixed priority
// instead, where the lowest-index valid channel always wins.
// A single output register stage sustains one transfer per cycle.
module mux_rr_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_sel
);

    logic            load_en;
    logic            gnt_valid;
    logic [SELW-1:0] gnt_idx;
    logic            xfer;
    logic [SELW-1:0] ptr;
    int unsigned     cand;

    // Output register can take a word when empty or being drained this cycle
    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && gnt_valid && !rst;

`ifdef MUX_STRICT_PRIO_EN
    // Fixed priority: search always starts at channel 0
    assign ptr = '0;
`else
    // Priority pointer moves to the channel after the one just served
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            if (gnt_idx == SELW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end
`endif

    // Grant the first valid channel found from ptr upward, wrapping modulo N
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_valid && in_valid[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(cand);
            end
        end
    end

    // Accept is one-hot on the granted channel and suppressed during reset
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output stage: load on transfer, clear valid on drain, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
            out_sel   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-input, WIDTH-bit registered stream multiplexer with round-robin arbitration and valid/ready handshakes. It generalises the 8-bit two-input data selector into a sequential channel merger. Typical use is merging several producers (ALU result, memory read, I/O port, immediate path) onto one 8-bit datapath bus into a register file or output port. It has one output register stage and sustains one transfer per cycle.

## Interface
- WIDTH, 8: data width in bits per channel; must be at least 1.
- N, 4: number of input channels; must be at least 2. SELW = $clog2(N).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. It is sampled on the rising edge of clk.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request; the data is valid while this bit is high.
- in_ready  output  N  per-channel accept (combinational). At most one bit is high.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered; out_data holds an unconsumed word.
- out_ready  input  1  downstream accept.
- out_sel  output  SELW  registered index of the channel that supplied out_data.

## Operation
- Transfer on input i: in_valid[i] && in_ready[i] on a rising edge. Transfer on output: out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register accepts a new word when it is empty or being drained in the same cycle.
- Arbitration is combinational over in_valid using the priority pointer ptr (SELW bits).
  - Grant goes to the first channel with valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - gnt_valid = |in_valid.
- in_ready[g] = load_en && gnt_valid for the granted channel g. All other in_ready bits are 0. in_ready never depends on in_ready.
- On a transfer from channel g:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g+1) mod N; when g = N-1 it wraps to 0. For non-power-of-two N, ptr never exceeds N-1.
- Output drained with no new transfer: out_valid <= 0. out_data and out_sel keep their last values.
- No transfer and no drain: all registers hold.
- Producers may deassert in_valid[i] at any time. A request is only consumed on a transfer.
- A channel granted but stalled (load_en = 0) gets no grant commitment. Arbitration re-evaluates every cycle against the current in_valid and ptr.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - During rst, in_ready = 0 and out_ready is ignored.
  - rst asserted mid-stream discards the held word. No transfer occurs on the reset edge, even if valid/ready are high.
- Latency: input transfer on edge k produces out_valid = 1 with that data after edge k, visible in cycle k+1.
- Throughput: 1 word/cycle when out_ready is held high. Back-to-back transfers alternate channels under contention.
- Backpressure: with out_valid = 1 and out_ready = 0, all in_ready = 0. out_data and out_sel must stay stable until the drain edge.
- Simultaneous drain and load: out_valid stays 1 and the data is replaced, with no bubble.
- Fairness: with all N channels continuously valid and out_ready = 1, each channel is granted exactly once in every N consecutive transfers.

## Configuration
- MUX_STRICT_PRIO_EN defined: fixed priority, and the lowest-index valid channel always wins.
  - ptr is not implemented; it is treated as constant 0.
  - Starvation of higher indices is permitted.
- MUX_STRICT_PRIO_EN undefined (default): round-robin as described above.
- All other behaviour is identical in both builds: handshake, latency, out_sel, and reset.

## Test plan
- Reset then idle, with N=4 and WIDTH=8: after rst held 2 cycles, out_valid=0, out_data=8'h00, out_sel=0, in_ready=4'b0000. With in_valid=0 for 5 cycles, nothing changes.
- Single channel: in_valid=4'b0100, channel 2 data 8'hA5, out_ready=1. Expect in_ready=4'b0100 the same cycle, then out_data=8'hA5, out_sel=2, out_valid=1 next cycle.
- Round-robin wrap: all channels valid, data i = 8'h10+i, out_ready=1.
  - Default build: out_sel sequence 0,1,2,3,0,1 and out_data 8'h10,11,12,13,10,11.
  - MUX_STRICT_PRIO_EN build: out_sel stays 0.
- Backpressure: word 8'h3C from channel 1 held with out_ready=0 for 3 cycles. Expect in_ready=0, and out_data=8'h3C and out_sel=1 stable. Raising out_ready with channel 3 valid (8'h7E) loads 8'h7E on the same edge, and out_valid stays 1.
- Reset mid-stream: out_valid=1 holding 8'h55, ptr=2. Assert rst for 1 cycle with all in_valid=1. Expect out_valid=0, out_data=0, and no transfer. After release, the first grant goes to channel 0.
- Parameter sweep, with N=3 and WIDTH=16: all valid gives out_sel 0,1,2,0 (wrap with non-power-of-two N), and 16-bit data passes unaltered.
